// File: rtl/cea_frame_rx_pkg.sv
// CEA frame receiver shared types: FSM states, error codes, frame layout constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cea_frame_rx_pkg;

  // One state per expected byte; DATA repeats CNT times.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ID_LO,
    ST_CNT_HI,
    ST_CNT_LO,
    ST_DATA,
    ST_CHK_HI,
    ST_CHK_LO
  } state_t;

  // err_code values reported with frame_err
  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_CHK = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

  // Byte positions within a frame
  localparam int POS_ID_HI  = 0;
  localparam int POS_ID_LO  = 1;
  localparam int POS_CNT_HI = 2;
  localparam int POS_CNT_LO = 3;
  localparam int POS_DATA   = 4;
  localparam int WORD_BYTES = 4;

  // Length is legal only when non-zero, whole words, and within the limit.
  function automatic logic len_bad(input logic [15:0] cnt, input logic [15:0] max_bytes);
    return (cnt == 16'd0) || (cnt[1:0] != 2'b00) || (cnt > max_bytes);
  endfunction

endpackage

// File: rtl/cea_frame_rx_if.sv
// Byte-in / status-out bundle between the bus byte receiver and cea_frame_rx.
// Latency: n/a (wires only).
// Backpressure: none; rx_flag is a 1-cycle strobe that must always be taken.
interface cea_frame_rx_if;
  logic [7:0]  rx_data;
  logic        rx_flag;
  logic [31:0] word_data;
  logic        word_flag;
  logic [15:0] frame_id;
  logic        frame_ok;
  logic        frame_err;
  logic [1:0]  err_code;
  logic        busy;

  // Byte source side: drives bytes, observes results
  modport master (
    output rx_data, rx_flag,
    input  word_data, word_flag, frame_id, frame_ok, frame_err, err_code, busy
  );

  // Frame receiver side
  modport slave (
    input  rx_data, rx_flag,
    output word_data, word_flag, frame_id, frame_ok, frame_err, err_code, busy
  );
endinterface

// File: rtl/cea_frame_rx_word_packer.sv
// Packs data bytes big-endian into 32-bit words.
// Latency: word_vld/word_dat one cycle after the 4th byte of a word.
// Backpressure: none; every byte_vld is consumed, words are strobed once.
module cea_frame_rx_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic        word_vld,
  output logic [31:0] word_dat
);

  logic [23:0] sh_q, sh_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        word_vld_q, word_vld_d;
  logic [31:0] word_dat_q, word_dat_d;

  // Shift in bytes; the 4th completes a word. clr restarts word alignment.
  always_comb begin
    sh_d       = sh_q;
    cnt_d      = cnt_q;
    word_vld_d = 1'b0;
    word_dat_d = word_dat_q;
    if (clr) begin
      sh_d  = '0;
      cnt_d = '0;
    end else if (byte_vld) begin
      cnt_d = cnt_q + 2'd1;
      sh_d  = {sh_q[15:0], byte_dat};
      if (cnt_q == 2'd3) begin
        word_vld_d = 1'b1;
        word_dat_d = {sh_q, byte_dat};
      end
    end
  end

  // Packer state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q       <= '0;
      cnt_q      <= '0;
      word_vld_q <= 1'b0;
      word_dat_q <= '0;
    end else begin
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
      word_vld_q <= word_vld_d;
      word_dat_q <= word_dat_d;
    end
  end

  assign word_vld = word_vld_q;
  assign word_dat = word_dat_q;

endmodule

// File: rtl/cea_frame_rx.sv
// CEA frame parser: ID, length, data words, 16-bit additive checksum, byte timeout. Optional ID filter: CEA_RX_ID_FILTER_EN.
// Latency: word, frame_ok and frame_err pulses appear one cycle after the byte that triggers them.
// Backpressure: none; a byte is taken on every rx_flag, including the cycle a status pulse is driven.
module cea_frame_rx
  import cea_frame_rx_pkg::*;
#(
  parameter logic [15:0] DEV_ID       = 16'h0001,
  parameter logic [15:0] MAX_BYTES    = 16'd64,
  parameter int          BYTE_TIMEOUT = 1000
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  cea_frame_rx_if.slave bus
);

`ifdef CEA_RX_ID_FILTER_EN
  localparam logic FILTER_EN = 1'b1;
`else
  localparam logic FILTER_EN = 1'b0;
`endif

  localparam int TW = (BYTE_TIMEOUT > 1) ? $clog2(BYTE_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(BYTE_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [7:0]    id_hi_q, id_hi_d;
  logic [7:0]    cnt_hi_q, cnt_hi_d;
  logic [7:0]    chk_hi_q, chk_hi_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   byte_cnt_q, byte_cnt_d;
  logic [15:0]   chk_q, chk_d;
  logic [15:0]   frame_id_q, frame_id_d;
  logic          id_match_q, id_match_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          frame_ok_q, frame_ok_d;
  logic          frame_err_q, frame_err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          busy_q, busy_d;

  logic          pk_clr;
  logic          pk_vld;

  // ID_HI restarts word alignment; only data bytes of an accepted ID are packed.
  assign pk_clr = bus.rx_flag && (state_q == ST_IDLE);
  assign pk_vld = bus.rx_flag && (state_q == ST_DATA) && id_match_q;

  cea_frame_rx_word_packer u_packer (
    .clk      (sys_clk),
    .rst_n    (sys_rst),
    .clr      (pk_clr),
    .byte_vld (pk_vld),
    .byte_dat (bus.rx_data),
    .word_vld (bus.word_flag),
    .word_dat (bus.word_data)
  );

  // Next-state, checksum, timeout and status-pulse logic
  always_comb begin
    state_d     = state_q;
    id_hi_d     = id_hi_q;
    cnt_hi_d    = cnt_hi_q;
    chk_hi_d    = chk_hi_q;
    cnt_d       = cnt_q;
    byte_cnt_d  = byte_cnt_q;
    chk_d       = chk_q;
    frame_id_d  = frame_id_q;
    id_match_d  = id_match_q;
    tmo_d       = tmo_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;

    // Inter-byte timeout; an arriving byte always beats expiry.
    if (state_q != ST_IDLE) begin
      if (bus.rx_flag) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_LAST) begin
        tmo_d       = '0;
        state_d     = ST_IDLE;
        frame_err_d = 1'b1;
        err_code_d  = ERR_TMO;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    if (bus.rx_flag) begin
      case (state_q)
        ST_IDLE: begin
          id_hi_d = bus.rx_data;
          chk_d   = {8'h00, bus.rx_data};
          tmo_d   = '0;
          state_d = ST_ID_LO;
        end
        ST_ID_LO: begin
          frame_id_d = {id_hi_q, bus.rx_data};
          id_match_d = !FILTER_EN || ({id_hi_q, bus.rx_data} == DEV_ID);
          chk_d      = chk_q + {8'h00, bus.rx_data};
          state_d    = ST_CNT_HI;
        end
        ST_CNT_HI: begin
          cnt_hi_d = bus.rx_data;
          chk_d    = chk_q + {8'h00, bus.rx_data};
          state_d  = ST_CNT_LO;
        end
        ST_CNT_LO: begin
          cnt_d      = {cnt_hi_q, bus.rx_data};
          byte_cnt_d = '0;
          chk_d      = chk_q + {8'h00, bus.rx_data};
          if (len_bad({cnt_hi_q, bus.rx_data}, MAX_BYTES)) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          chk_d      = chk_q + {8'h00, bus.rx_data};
          byte_cnt_d = byte_cnt_q + 16'd1;
          if (byte_cnt_q + 16'd1 == cnt_q) begin
            state_d = ST_CHK_HI;
          end
        end
        ST_CHK_HI: begin
          chk_hi_d = bus.rx_data;
          state_d  = ST_CHK_LO;
        end
        ST_CHK_LO: begin
          state_d = ST_IDLE;
          // A filtered-out ID is consumed silently.
          if (id_match_q) begin
            if ({chk_hi_q, bus.rx_data} == chk_q) begin
              frame_ok_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
              err_code_d  = ERR_CHK;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // FSM state and registered outputs
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q     <= ST_IDLE;
      id_hi_q     <= '0;
      cnt_hi_q    <= '0;
      chk_hi_q    <= '0;
      cnt_q       <= '0;
      byte_cnt_q  <= '0;
      chk_q       <= '0;
      frame_id_q  <= '0;
      id_match_q  <= 1'b0;
      tmo_q       <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_hi_q     <= id_hi_d;
      cnt_hi_q    <= cnt_hi_d;
      chk_hi_q    <= chk_hi_d;
      cnt_q       <= cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      chk_q       <= chk_d;
      frame_id_q  <= frame_id_d;
      id_match_q  <= id_match_d;
      tmo_q       <= tmo_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.frame_id  = frame_id_q;
  assign bus.frame_ok  = frame_ok_q;
  assign bus.frame_err = frame_err_q;
  assign bus.err_code  = err_code_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_cea_frame_rx.sv
// Directed bench for cea_frame_rx: valid/bad frames, length and timeout errors, back-to-back, reset.
// Latency: checks pulses one cycle after the triggering byte.
// Backpressure: none; bytes are driven as 1-cycle strobes.
module tb_cea_frame_rx;

  localparam int T = 1000;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;
  always #5 sys_clk = ~sys_clk;

  cea_frame_rx_if bus ();

  cea_frame_rx #(
    .DEV_ID       (16'h0001),
    .MAX_BYTES    (16'd64),
    .BYTE_TIMEOUT (T)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  int err_cnt = 0;
  int chk_cnt = 0;
  int n_word  = 0;
  int n_ok    = 0;
  int n_err   = 0;
  int n_both  = 0;

  logic [31:0] got_w[$];
  logic [31:0] exp_w[$];
  logic [7:0]  tx[$];

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse monitor, sampled mid-cycle
  always @(negedge sys_clk) begin
    if (bus.word_flag) begin
      n_word++;
      got_w.push_back(bus.word_data);
    end
    if (bus.frame_ok)  n_ok++;
    if (bus.frame_err) n_err++;
    if (bus.frame_ok && bus.frame_err) n_both++;
  end

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_flag = 1'b1;
    @(posedge sys_clk);
    #1;
    bus.rx_flag = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic send_q();
    while (tx.size() > 0) send_byte(tx.pop_front());
  endtask

  // Legal frame of cnt bytes base, base+1, ...; queues bytes and expected words.
  task automatic add_frame(input logic [15:0] id, input logic [15:0] cnt, input logic [7:0] base);
    logic [15:0] sum;
    logic [31:0] w;
    logic [7:0]  b;
    sum = 16'(id[15:8]) + 16'(id[7:0]) + 16'(cnt[15:8]) + 16'(cnt[7:0]);
    tx.push_back(id[15:8]);
    tx.push_back(id[7:0]);
    tx.push_back(cnt[15:8]);
    tx.push_back(cnt[7:0]);
    w = '0;
    for (int i = 0; i < int'(cnt); i++) begin
      b = base + 8'(i);
      tx.push_back(b);
      sum = sum + 16'(b);
      w = {w[23:0], b};
      if ((i % 4) == 3) exp_w.push_back(w);
    end
    tx.push_back(sum[15:8]);
    tx.push_back(sum[7:0]);
  endtask

  task automatic cmp_words(input string tag);
    chk_eq({tag, "_nwords"}, 32'(got_w.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size(); i++) begin
      chk_eq($sformatf("%s_w%0d", tag, i), (i < got_w.size()) ? got_w[i] : 32'hxxxxxxxx, exp_w[i]);
    end
  endtask

  // Hang guard
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", err_cnt + 1, chk_cnt + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, o0, e0, n;
    bus.rx_data = 8'h00;
    bus.rx_flag = 1'b0;

    // Reset state
    #1;
    chk_eq("rst_word_flag", 32'(bus.word_flag), 32'd0);
    chk_eq("rst_word_data", bus.word_data, 32'd0);
    chk_eq("rst_frame_ok", 32'(bus.frame_ok), 32'd0);
    chk_eq("rst_frame_err", 32'(bus.frame_err), 32'd0);
    chk_eq("rst_err_code", 32'(bus.err_code), 32'd0);
    chk_eq("rst_busy", 32'(bus.busy), 32'd0);
    chk_eq("rst_frame_id", 32'(bus.frame_id), 32'd0);
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    idle(1);

    // 1: one-word frame, good checksum 0x0014
    tx = '{8'h00, 8'h01, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h0F};
    send_q();
    chk_eq("t1_word_flag", 32'(bus.word_flag), 32'd1);
    chk_eq("t1_word_data", bus.word_data, 32'h0000000F);
    chk_eq("t1_busy", 32'(bus.busy), 32'd1);
    send_byte(8'h00);
    chk_eq("t1_word_flag_off", 32'(bus.word_flag), 32'd0);
    send_byte(8'h14);
    chk_eq("t1_frame_ok", 32'(bus.frame_ok), 32'd1);
    chk_eq("t1_frame_err", 32'(bus.frame_err), 32'd0);
    chk_eq("t1_frame_id", 32'(bus.frame_id), 32'h0001);
    chk_eq("t1_busy_end", 32'(bus.busy), 32'd0);
    idle(1);
    chk_eq("t1_ok_pulse_1cyc", 32'(bus.frame_ok), 32'd0);

    // 2: same frame, checksum 0x0015
    w0 = n_word; o0 = n_ok; e0 = n_err;
    tx = '{8'h00, 8'h01, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h15};
    send_q();
    chk_eq("t2_frame_err", 32'(bus.frame_err), 32'd1);
    chk_eq("t2_err_code", 32'(bus.err_code), 32'd2);
    chk_eq("t2_frame_ok", 32'(bus.frame_ok), 32'd0);
    idle(1);
    chk_eq("t2_words", 32'(n_word - w0), 32'd1);
    chk_eq("t2_oks", 32'(n_ok - o0), 32'd0);
    chk_eq("t2_errs", 32'(n_err - e0), 32'd1);

    // 3: CNT=3, then a clean frame starting on the error-pulse cycle
    tx = '{8'h00, 8'h01, 8'h00, 8'h03};
    send_q();
    chk_eq("t3_len_err", 32'(bus.frame_err), 32'd1);
    chk_eq("t3_len_code", 32'(bus.err_code), 32'd1);
    chk_eq("t3_len_busy", 32'(bus.busy), 32'd0);
    tx = '{8'h00, 8'h01, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h14};
    send_q();
    chk_eq("t3_next_ok", 32'(bus.frame_ok), 32'd1);
    chk_eq("t3_code_held", 32'(bus.err_code), 32'd1);
    // CNT=0x44 exceeds 64, CNT=0 empty: both LEN
    tx = '{8'h00, 8'h01, 8'h00, 8'h44};
    send_q();
    chk_eq("t3_big_err", 32'(bus.frame_err), 32'd1);
    chk_eq("t3_big_code", 32'(bus.err_code), 32'd1);
    idle(1);
    tx = '{8'h00, 8'h01, 8'h00, 8'h00};
    send_q();
    chk_eq("t3_zero_err", 32'(bus.frame_err), 32'd1);
    chk_eq("t3_zero_code", 32'(bus.err_code), 32'd1);
    idle(1);

    // 4: timeout after CNT_HI
    tx = '{8'h00, 8'h01, 8'h00};
    send_q();
    n = 0;
    for (int k = 1; k <= T + 10; k++) begin
      idle(1);
      n = k;
      if (bus.frame_err) break;
    end
    chk_eq("t4_tmo_cycles", 32'(n), 32'(T));
    chk_eq("t4_tmo_err", 32'(bus.frame_err), 32'd1);
    chk_eq("t4_tmo_code", 32'(bus.err_code), 32'd3);
    chk_eq("t4_tmo_busy", 32'(bus.busy), 32'd0);
    idle(1);

    // 4b: byte arriving on the expiry cycle wins
    e0 = n_err;
    tx = '{8'h00, 8'h01, 8'h00};
    send_q();
    idle(T - 1);
    send_byte(8'h04);
    chk_eq("t4b_no_err", 32'(bus.frame_err), 32'd0);
    chk_eq("t4b_busy", 32'(bus.busy), 32'd1);
    tx = '{8'h00, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h14};
    send_q();
    chk_eq("t4b_ok", 32'(bus.frame_ok), 32'd1);
    idle(1);
    chk_eq("t4b_errs", 32'(n_err - e0), 32'd0);

    // 5: two 8-byte frames back-to-back, rx_flag high throughout
    got_w.delete();
    exp_w = '{32'h11223344, 32'h55667788, 32'h01020304, 32'h05060708};
    w0 = n_word; o0 = n_ok; e0 = n_err;
    tx = '{8'h00, 8'h01, 8'h00, 8'h08, 8'h11, 8'h22, 8'h33, 8'h44,
           8'h55, 8'h66, 8'h77, 8'h88, 8'h02, 8'h6D,
           8'h00, 8'h01, 8'h00, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04,
           8'h05, 8'h06, 8'h07, 8'h08, 8'h00, 8'h2D};
    send_q();
    chk_eq("t5_last_ok", 32'(bus.frame_ok), 32'd1);
    idle(1);
    chk_eq("t5_oks", 32'(n_ok - o0), 32'd2);
    chk_eq("t5_errs", 32'(n_err - e0), 32'd0);
    chk_eq("t5_nflags", 32'(n_word - w0), 32'd4);
    cmp_words("t5");

    // Largest legal frame: 64 data bytes
    got_w.delete();
    exp_w.delete();
    add_frame(16'h0001, 16'd64, 8'h00);
    send_q();
    chk_eq("max_ok", 32'(bus.frame_ok), 32'd1);
    idle(1);
    cmp_words("max");

    // 6: reset during DATA
    tx = '{8'h00, 8'h01, 8'h00, 8'h08, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_q();
    o0 = n_ok; e0 = n_err;
    #2;
    sys_rst = 1'b0;
    #1;
    chk_eq("t6_rst_busy", 32'(bus.busy), 32'd0);
    chk_eq("t6_rst_id", 32'(bus.frame_id), 32'd0);
    chk_eq("t6_rst_word", bus.word_data, 32'd0);
    chk_eq("t6_rst_code", 32'(bus.err_code), 32'd0);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    idle(2);
    chk_eq("t6_no_pulse", 32'((n_ok - o0) + (n_err - e0)), 32'd0);
    tx = '{8'h00, 8'h01, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h14};
    send_q();
    chk_eq("t6_clean_ok", 32'(bus.frame_ok), 32'd1);
    idle(1);

`ifdef CEA_RX_ID_FILTER_EN
    // Foreign ID 0x0002, valid checksum 0x0015: consumed silently
    w0 = n_word; o0 = n_ok; e0 = n_err;
    tx = '{8'h00, 8'h02, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h15};
    send_q();
    idle(1);
    chk_eq("flt_words", 32'(n_word - w0), 32'd0);
    chk_eq("flt_oks", 32'(n_ok - o0), 32'd0);
    chk_eq("flt_errs", 32'(n_err - e0), 32'd0);
    chk_eq("flt_busy", 32'(bus.busy), 32'd0);
    tx = '{8'h00, 8'h02, 8'h00, 8'h03};
    send_q();
    chk_eq("flt_len_err", 32'(bus.frame_err), 32'd1);
    chk_eq("flt_len_code", 32'(bus.err_code), 32'd1);
    idle(1);
`endif

    chk_eq("ok_err_exclusive", 32'(n_both), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
